// File: rtl/sampler_if.sv
// Bus bundle for the sampler: sample stream, buffer read port, CSR port and interrupt.
// The sampler connects through the slave modport; the data source / bus side uses master.
interface sampler_if #(
   parameter int INPUT_BITS = 32,
   parameter int TIME_BITS  = 10
);
   logic [INPUT_BITS-1:0] s_in;
   logic                  s_valid;
   logic                  s_trigger;
   logic                  buffer_read;
   logic [TIME_BITS-1:0]  buffer_address;
   logic [31:0]           buffer_readdata;
   logic                  csr_write;
   logic [31:0]           csr_writedata;
   logic                  csr_read;
   logic [31:0]           csr_readdata;
   logic                  irq;

   modport slave (
      input  s_in, s_valid, s_trigger,
      input  buffer_read, buffer_address,
      output buffer_readdata,
      input  csr_write, csr_writedata, csr_read,
      output csr_readdata, irq
   );

   modport master (
      output s_in, s_valid, s_trigger,
      output buffer_read, buffer_address,
      input  buffer_readdata,
      output csr_write, csr_writedata, csr_read,
      input  csr_readdata, irq
   );
endinterface

// File: rtl/sampler.sv
// Trigger-started capture of a sample stream into a 2**TIME_BITS word buffer,
// read back over a memory-mapped slave, controlled by a one-word CSR with completion irq.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | stopped; waits for an arm write
// S_ARMED   | waiting for s_trigger or a force write
// S_CAPTURE | storing each valid sample at buffer[count]
// S_DONE    | buffer full, irq raised; count held at 2**TIME_BITS
module sampler #(
   parameter int INPUT_BITS = 32,
   parameter int TIME_BITS  = 10
) (
   input  logic      clk,
   input  logic      reset,
   sampler_if.slave  bus
);
   localparam int DEPTH = 1 << TIME_BITS;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

   state_t               r_state;
   logic [TIME_BITS:0]   r_count;
   logic                 r_irq;
   logic [31:0]          r_csr_rd;
   logic [31:0]          r_buf_rd;
   logic [31:0]          r_mem [DEPTH];

   logic                 w_wr;
   logic                 w_last;
   logic                 w_arm;
   logic                 w_force;
   logic                 w_busy;
   logic                 w_done;
   logic                 w_triggered;
   logic [31:0]          w_sample;
   logic [31:0]          w_csr_word;

   assign w_wr        = (r_state == S_CAPTURE) && bus.s_valid;
   assign w_last      = w_wr && (r_count == (TIME_BITS+1)'(DEPTH-1));
   assign w_arm       = bus.csr_writedata[0];
   assign w_force     = bus.csr_writedata[1];
   assign w_busy      = (r_state == S_ARMED) || (r_state == S_CAPTURE);
   assign w_done      = (r_state == S_DONE);
   assign w_triggered = (r_state == S_CAPTURE) || (r_state == S_DONE);
   assign w_sample    = 32'(bus.s_in);
   assign w_csr_word  = {16'(r_count), 12'd0, w_triggered, r_irq, w_done, w_busy};

   // Buffer has no reset so captured data survives a reset.
   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_count[TIME_BITS-1:0]] <= w_sample;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_buf_rd <= 32'd0;
         r_csr_rd <= 32'd0;
      end else begin
         if (bus.buffer_read)
            r_buf_rd <= r_mem[bus.buffer_address];
         if (bus.csr_read)
            r_csr_rd <= w_csr_word;
      end
   end

   // Completing the final sample outranks any CSR write on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_irq   <= 1'b0;
      end else begin
         if (w_wr)
            r_count <= r_count + 1'b1;
         if (w_last) begin
            r_state <= S_DONE;
            r_irq   <= 1'b1;
         end else if (bus.csr_write) begin
            r_irq <= 1'b0;
            case (r_state)
               S_IDLE, S_DONE: begin
                  if (w_arm) begin
                     r_count <= '0;
                     r_state <= w_force ? S_CAPTURE : S_ARMED;
                  end
               end
               S_ARMED: begin
                  if (!w_arm)
                     r_state <= S_IDLE;
                  else if (w_force || bus.s_trigger)
                     r_state <= S_CAPTURE;
               end
               S_CAPTURE: begin
                  if (!w_arm)
                     r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end else if ((r_state == S_ARMED) && bus.s_trigger) begin
            r_state <= S_CAPTURE;
         end
      end
   end

   assign bus.irq             = r_irq;
   assign bus.csr_readdata    = r_csr_rd;
   assign bus.buffer_readdata = r_buf_rd;
endmodule

// File: tb/tb_sampler.sv
// Directed bench for sampler (12-bit input, 16-word buffer): stimulus queues expected
// read data, a monitor pops and compares whenever a read strobe was taken.
module tb_sampler;
   localparam int IB = 12;
   localparam int TB = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sampler_if #(.INPUT_BITS(IB), .TIME_BITS(TB)) bus ();
   sampler #(.INPUT_BITS(IB), .TIME_BITS(TB)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] q_csr[$];
   logic [31:0] q_buf[$];
   logic        m_csr;
   logic        m_buf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic wr, input logic [31:0] wd, input logic rd,
                        input logic brd, input logic [TB-1:0] addr,
                        input logic vld, input logic [IB-1:0] din, input logic trg);
      bus.csr_write      = wr;
      bus.csr_writedata  = wd;
      bus.csr_read       = rd;
      bus.buffer_read    = brd;
      bus.buffer_address = addr;
      bus.s_valid        = vld;
      bus.s_in           = din;
      bus.s_trigger      = trg;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0, 12'd0, 1'b0);
   endtask

   task automatic csr_wr(input logic [31:0] d);
      drive(1'b1, d, 1'b0, 1'b0, 4'd0, 1'b0, 12'd0, 1'b0);
   endtask

   task automatic csr_rd(input logic [31:0] exp);
      q_csr.push_back(exp);
      drive(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b0, 12'd0, 1'b0);
   endtask

   task automatic buf_rd(input logic [TB-1:0] a, input logic [31:0] exp);
      q_buf.push_back(exp);
      drive(1'b0, 32'd0, 1'b0, 1'b1, a, 1'b0, 12'd0, 1'b0);
   endtask

   task automatic sample(input logic [IB-1:0] d);
      drive(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1, d, 1'b0);
   endtask

   task automatic trigger();
      drive(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1, 12'hABC, 1'b1);
   endtask

   // Monitor: a read strobe seen at an edge means readdata is valid just after it.
   initial begin
      forever begin
         @(posedge clk);
         m_csr = bus.csr_read;
         m_buf = bus.buffer_read;
         #1;
         if (m_csr) begin
            if (q_csr.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL csr_readdata: got 0x%08h with no expected entry", bus.csr_readdata);
            end else begin
               chk("csr_readdata", bus.csr_readdata, q_csr.pop_front());
            end
         end
         if (m_buf) begin
            if (q_buf.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL buffer_readdata: got 0x%08h with no expected entry", bus.buffer_readdata);
            end else begin
               chk("buffer_readdata", bus.buffer_readdata, q_buf.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.csr_write = 1'b0; bus.csr_writedata = 32'd0; bus.csr_read = 1'b0;
      bus.buffer_read = 1'b0; bus.buffer_address = '0;
      bus.s_valid = 1'b0; bus.s_in = '0; bus.s_trigger = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      chk("reset_irq", 32'(bus.irq), 32'd0);
      chk("reset_csr_readdata", bus.csr_readdata, 32'd0);
      chk("reset_buffer_readdata", bus.buffer_readdata, 32'd0);
      csr_rd(32'h0000_0000);

      // Full capture: armed samples before the trigger and the trigger-cycle sample are ignored.
      csr_wr(32'h1);
      sample(12'h5A5);
      sample(12'h5A5);
      trigger();
      for (int i = 0; i < 16; i++) begin
         sample(12'(i));
         chk("irq_full_capture", 32'(bus.irq), (i == 15) ? 32'd1 : 32'd0);
      end
      sample(12'hFFF);
      sample(12'hFFF);
      csr_rd(32'h0010_000E);
      for (int i = 0; i < 16; i++) buf_rd(4'(i), 32'(i));

      // Force-armed capture with s_valid toggling; six valid samples.
      csr_wr(32'h3);
      chk("irq_cleared_by_write", 32'(bus.irq), 32'd0);
      for (int k = 0; k < 12; k++) begin
         if (k % 2 == 0) sample(12'h0F00 + 12'(k / 2));
         else drive(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0, 12'hEEE, 1'b0);
      end
      csr_rd(32'h0006_0009);
      for (int j = 0; j < 6; j++) buf_rd(4'(j), 32'h0F00 + 32'(j));
      buf_rd(4'd6, 32'd6);

      // Abort keeps count; re-arm clears it.
      csr_wr(32'h0);
      csr_rd(32'h0006_0000);
      csr_wr(32'h1);
      trigger();
      for (int k = 0; k < 5; k++) sample(12'h050 + 12'(k));
      csr_wr(32'h0);
      csr_rd(32'h0005_0000);
      chk("irq_after_abort", 32'(bus.irq), 32'd0);
      csr_wr(32'h1);
      csr_rd(32'h0000_0001);

      // Final sample coincides with an abort write and a same-address read.
      trigger();
      for (int k = 0; k < 15; k++) sample(12'h700 + 12'(k));
      q_buf.push_back(32'd15);
      drive(1'b1, 32'h0, 1'b0, 1'b1, 4'd15, 1'b1, 12'h70F, 1'b0);
      chk("irq_final_edge_write", 32'(bus.irq), 32'd1);
      csr_rd(32'h0010_000E);
      buf_rd(4'd15, 32'h0000_070F);
      csr_wr(32'h0);
      chk("irq_cleared_after_done", 32'(bus.irq), 32'd0);
      csr_rd(32'h0010_000A);

      // Same-edge read and write: read returns the pre-write state.
      q_csr.push_back(32'h0010_000A);
      drive(1'b1, 32'h1, 1'b1, 1'b0, 4'd0, 1'b0, 12'd0, 1'b0);
      csr_rd(32'h0000_0001);

      // Asynchronous reset mid-capture.
      trigger();
      q_csr.push_back(32'h0000_0009);
      q_buf.push_back(32'h0000_070F);
      drive(1'b0, 32'd0, 1'b1, 1'b1, 4'd15, 1'b1, 12'h3A0, 1'b0);
      sample(12'h3A1);
      idle(1);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("async_reset_irq", 32'(bus.irq), 32'd0);
      chk("async_reset_csr_readdata", bus.csr_readdata, 32'd0);
      chk("async_reset_buffer_readdata", bus.buffer_readdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      csr_rd(32'h0000_0000);
      buf_rd(4'd0, 32'h0000_03A0);
      buf_rd(4'd1, 32'h0000_03A1);
      buf_rd(4'd2, 32'h0000_0702);

      idle(2);
      chk("csr_queue_drained", 32'(q_csr.size()), 32'd0);
      chk("buf_queue_drained", 32'(q_buf.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
